// File: rtl/mod_count_ctrl.sv
// mod_count_ctrl: windowed event counter with modulus-hit pulses, overflow flag
// and a valid/ready result handshake; three-state FSM (IDLE, COUNT, REPORT).
module mod_count_ctrl #(
  parameter int CW = 4,
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] modulus,
  input  logic [WW-1:0] win_len,
  input  logic          ain,
  output logic          busy,
  output logic          yout,
  output logic [CW-1:0] countout,
  output logic          ovf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_hits,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  state_t state_q, state_d;
  logic [CW-1:0] mod_q, mod_d, cnt_q, cnt_d, res_q, res_d, hits_q, hits_d;
  logic [WW-1:0] rem_q, rem_d;
  logic ovf_q, ovf_d, yout_q, yout_d, err_q, err_d, hit;
  always_comb begin
    state_d = state_q;
    mod_d = mod_q;
    cnt_d = cnt_q;
    res_d = res_q;
    hits_d = hits_q;
    rem_d = rem_q;
    ovf_d = ovf_q;
    yout_d = 1'b0;
    err_d = 1'b0;
    hit = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (modulus != '0 && win_len != '0) begin
          state_d = COUNT;
          mod_d = modulus;
          rem_d = win_len;
          cnt_d = '0;
          res_d = '0;
          hits_d = '0;
          ovf_d = 1'b0;
        end else err_d = 1'b1;
      end
      COUNT: if (abort) state_d = IDLE;
      else begin
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == WW'(1)) ? REPORT : COUNT;
        if (ain) begin
          // residue tracks events mod modulus; a hit resets it
          hit = (res_q == mod_q - 1'b1);
          cnt_d = cnt_q + 1'b1;
          ovf_d = ovf_q | (cnt_q == CMAX);
          res_d = hit ? '0 : res_q + 1'b1;
          hits_d = hits_q + CW'(hit && hits_q != CMAX);
          yout_d = hit;
        end
      end
      REPORT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mod_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      hits_q <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
      yout_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q <= mod_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      hits_q <= hits_d;
      rem_q <= rem_d;
      ovf_q <= ovf_d;
      yout_q <= yout_d;
      err_q <= err_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);
  assign yout = yout_q;
  assign countout = cnt_q;
  assign ovf = ovf_q;
  assign res_hits = hits_q;
  assign err = err_q;
endmodule

// File: tb/tb_mod_count_ctrl.sv
// tb_mod_count_ctrl: directed scenarios with literal expectations plus random
// stimulus checked every cycle against an event-count model of the window.
module tb_mod_count_ctrl;
  localparam int CW = 4;
  localparam int WW = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, ain = 1'b0, res_ready = 1'b0;
  logic [CW-1:0] modulus = '0;
  logic [WW-1:0] win_len = '0;
  logic busy, yout, ovf, res_valid, err;
  logic [CW-1:0] countout, res_hits;
  int checks = 0, errors = 0;
  int m_state = 0, m_mod = 1, m_rem = 0, m_ev = 0, m_yout = 0, m_err = 0;

  mod_count_ctrl #(.CW(CW), .WW(WW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .modulus(modulus),
    .win_len(win_len), .ain(ain), .busy(busy), .yout(yout), .countout(countout),
    .ovf(ovf), .res_valid(res_valid), .res_ready(res_ready), .res_hits(res_hits),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  // Model: m_ev is the unbounded event count of the window; every output is
  // derived from it arithmetically.
  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0; m_mod = 1; m_rem = 0; m_ev = 0; m_yout = 0; m_err = 0;
    end else begin
      m_yout = 0;
      m_err = 0;
      case (m_state)
        0: if (start) begin
          if (modulus != 0 && win_len != 0) begin
            m_mod = int'(modulus); m_rem = int'(win_len); m_ev = 0; m_state = 1;
          end else m_err = 1;
        end
        1: if (abort) m_state = 0;
        else begin
          if (ain) begin
            m_ev++;
            if (m_ev % m_mod == 0) m_yout = 1;
          end
          if (m_rem == 1) m_state = 2;
          m_rem--;
        end
        default: if (res_ready) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_state != 0);
    chk("res_valid", res_valid, m_state == 2);
    chk("yout", yout, m_yout);
    chk("err", err, m_err);
    chk("countout", countout, m_ev % (CMAX + 1));
    chk("ovf", ovf, m_ev > CMAX);
    chk("res_hits", res_hits, (m_ev / m_mod > CMAX) ? CMAX : m_ev / m_mod);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int m, input int w);
    modulus = CW'(m); win_len = WW'(w); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int ny;
  logic [CW-1:0] hold_c, hold_h;

  initial begin
    reset = 1'b0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_count", countout, 0);
    reset = 1'b1;
    // normal window: modulus 3, 10 events
    go(3, 10);
    ny = 0;
    ain = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); ny += int'(yout); end
    ain = 1'b0;
    chk("normal_rv_cycle11", res_valid, 1);
    for (int i = 0; i < 2; i++) begin tick(); ny += int'(yout); end
    chk("normal_ypulses", ny, 3);
    chk("normal_count", countout, 10);
    chk("normal_hits", res_hits, 3);
    // handshake stall with start held
    start = 1'b1;
    hold_c = countout; hold_h = res_hits;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("hs_valid", res_valid, 1);
      chk("hs_count", countout, hold_c);
      chk("hs_hits", res_hits, hold_h);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("hs_exit_busy", busy, 0);
    tick();
    chk("hs_no_new_window", busy, 0);
    // rejected starts
    go(0, 5);
    chk("err_mod0", err, 1);
    chk("err_mod0_idle", busy, 0);
    tick();
    chk("err_pulse_end", err, 0);
    go(5, 0);
    chk("err_win0", err, 1);
    chk("err_win0_count", countout, 10);
    tick();
    // wrap and saturation
    go(1, 20);
    ain = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    ain = 1'b0;
    chk("wrap_count", countout, 4);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_hits", res_hits, 15);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    // abort after 5 events
    go(2, 50);
    ain = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; ain = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_count", countout, 5);
    chk("abort_hits", res_hits, 2);
    chk("abort_no_rv", res_valid, 0);
    // reset mid-window after 4 events
    go(3, 20);
    ain = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; ain = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_count", countout, 0);
    chk("rst_hits", res_hits, 0);
    chk("rst_yout", yout, 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) == 0);
      modulus = CW'($urandom_range(0, CMAX));
      win_len = ($urandom_range(0, 9) == 0) ? '0 : WW'($urandom_range(1, 40));
      ain = ($urandom_range(0, 2) != 0);
      abort = ($urandom_range(0, 39) == 0);
      res_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_count_ctrl.md
MOD_COUNT_CTRL -- requirements
Module: mod_count_ctrl

Interface
REQ-001 Parameter CW, default 4, width of the event count and hit count.
REQ-002 Parameter WW, default 8, width of the window-length field.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 start  input  1  request to begin one counting window; sampled only in IDLE.
REQ-006 abort  input  1  cancel the running window; sampled only in COUNT.
REQ-007 modulus  input  CW  hit modulus, latched at start; legal range 1..2^CW-1.
REQ-008 win_len  input  WW  window length in clk cycles, latched at start; legal range 1..2^WW-1.
REQ-009 ain  input  1  event input; one event per cycle max.
REQ-010 busy  output  1  high in COUNT and REPORT.
REQ-011 yout  output  1  registered one-cycle pulse, one cycle after each modulus hit.
REQ-012 countout  output  CW  live event count of the current window (wraps).
REQ-013 ovf  output  1  sticky; set when countout wraps in the current window.
REQ-014 res_valid  output  1  result-valid handshake.
REQ-015 res_ready  input  1  result-accept handshake.
REQ-016 res_hits  output  CW  modulus hits in the window, saturating at 2^CW-1.
REQ-017 err  output  1  one-cycle pulse on rejected start.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, COUNT and REPORT.
REQ-019 IDLE with start=1, modulus!=0 and win_len!=0 SHALL latch both fields, clear countout, residue, res_hits and ovf, load the remaining-cycle counter with win_len, and enter COUNT next cycle.
REQ-020 IDLE with start=1 and modulus=0 or win_len=0 SHALL pulse err for one cycle, stay in IDLE and leave all other outputs unchanged.
REQ-021 Window cycles SHALL be the win_len cycles following the start cycle; ain SHALL be counted only in those cycles, and ain in the start cycle SHALL be ignored.
REQ-022 Each COUNT cycle SHALL decrement the remaining counter; the cycle in which it equals 1 is the last window cycle, after which the FSM enters REPORT.
REQ-023 On ain=1 in COUNT, countout SHALL increment modulo 2^CW; on a wrap from 2^CW-1 to 0, ovf SHALL set.
REQ-024 On ain=1 in COUNT, if residue=modulus-1: residue SHALL clear to 0, res_hits SHALL increment (saturating), and yout SHALL be 1 in the following cycle; otherwise residue SHALL increment.
REQ-025 With modulus=1, every accepted ain SHALL be a hit.
REQ-026 An ain accepted in the last window cycle SHALL be fully counted; its yout pulse SHALL appear in the first REPORT cycle.
REQ-027 abort=1 in COUNT SHALL return the FSM to IDLE next cycle with no REPORT and no res_valid; an ain in the same cycle SHALL be discarded; countout, res_hits and ovf SHALL retain their values; a yout already scheduled SHALL still fire.
REQ-028 abort and ain while outside COUNT SHALL have no effect.
REQ-029 In REPORT, res_valid SHALL be 1 and res_hits, countout and ovf SHALL be held stable until the cycle in which res_ready=1, after which the FSM returns to IDLE with res_valid=0.
REQ-030 res_ready SHALL have no effect while res_valid=0; start SHALL be ignored in COUNT and REPORT, including in the cycle REPORT exits.
REQ-031 countout, res_hits and ovf SHALL keep their last values in IDLE until the next accepted start.

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, busy=0, yout=0, countout=0, ovf=0, res_valid=0, res_hits=0, err=0, and clear the residue, the latched fields and the remaining counter, regardless of state.
REQ-033 Reset SHALL override start, abort and res_ready in the same cycle; a pending yout pulse SHALL be dropped.

Verification
REQ-034 Normal: modulus=3, win_len=10, ain=1 in all 10 window cycles -> countout=10, res_hits=3, yout pulses after events 3, 6 and 9, res_valid=1 from cycle 11.
REQ-035 Errors: start with modulus=0 -> err=1 for one cycle, state IDLE; start with win_len=0 -> same.
REQ-036 Wrap: modulus=1, win_len=20, ain held at 1 -> countout=4, ovf=1, res_hits=15 (saturated).
REQ-037 Abort: modulus=2, win_len=50, 5 events then abort with ain=1 -> IDLE next cycle, countout=5, res_valid never 1.
REQ-038 Handshake: hold res_ready=0 for 7 cycles in REPORT with start=1 throughout -> res_valid and results stable; res_ready=1 -> IDLE next cycle, no new window.
REQ-039 Reset mid-COUNT: reset=0 for one cycle after 4 events -> all outputs 0 and state IDLE next cycle.
